// File: rtl/stm1_frmsync.sv
`default_nettype none
// ============================================================================
//  Module   : stm1_frmsync
//  Purpose  : STM-1 frame synchroniser on the 19.44 MHz byte stream. Finds
//             the A1A1A1A2A2A2 alignment word, tracks the row/column of the
//             byte on dout, runs the OOF/LOF state machines and delivers the
//             aligned bytes with a start-of-frame marker.
//  Ports    : clk19   - byte clock
//             rst19_n - asynchronous active-low reset
//             din     - received byte (MSB first-received)
//             din_en  - din valid this clock
//             dout    - din delayed by 6 enabled bytes
//             dout_en - dout valid (din_en delayed one clock)
//             sofo    - dout is the first A1 of an aligned frame
//             rowo    - row of the dout byte (0..8), 0 while hunting
//             colo    - column of the dout byte (0..269), 0 while hunting
//             oof     - out-of-frame
//             lof     - loss-of-frame
//             fas_err - one-clock pulse when a scheduled FAS check fails
//  Revision : 1.0 - initial release
// ============================================================================
module stm1_frmsync #(
   parameter logic [7:0] A1      = 8'hF6,
   parameter logic [7:0] A2      = 8'h28,
   parameter int         FRM_LEN = 2430,
   parameter int         GOOD_N  = 2,
   parameter int         BAD_N   = 4,
   parameter int         LOF_FRM = 24
) (
   input  logic       clk19,
   input  logic       rst19_n,
   input  logic [7:0] din,
   input  logic       din_en,
   output logic [7:0] dout,
   output logic       dout_en,
   output logic       sofo,
   output logic [3:0] rowo,
   output logic [8:0] colo,
   output logic       oof,
   output logic       lof,
   output logic       fas_err
);

   localparam int          c_COLS     = 270;
   localparam int          c_ROWS     = FRM_LEN / c_COLS;
   localparam logic [8:0]  c_COL_LAST = 9'(c_COLS - 1);
   localparam logic [3:0]  c_ROW_LAST = 4'(c_ROWS - 1);
   localparam logic [2:0]  c_GOOD     = 3'(GOOD_N);
   localparam logic [2:0]  c_BAD      = 3'(BAD_N);
   localparam logic [15:0] c_LOF_CNT  = 16'(LOF_FRM * FRM_LEN);

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PRESYNC = 2'd1,
      ST_SYNC    = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_good;
   logic [2:0]  w_good_nxt;
   logic [2:0]  r_bad;
   logic [2:0]  w_bad_nxt;
   logic        w_fas_err;
   logic        w_load;
   logic        w_oof_nxt;

   logic [7:0]  r_dly [0:5];
   logic [3:0]  r_row;
   logic [8:0]  r_col;
   logic [3:0]  w_row_nxt;
   logic [8:0]  w_col_nxt;
   logic        w_pos_zero;
   logic        w_at_fas;
   logic        w_win_ok;

   logic [15:0] r_lcnt;
   logic [15:0] w_lcnt_inc;

   // r_row/r_col hold the position of the byte currently on dout; the *_nxt
   // values are the position of the byte about to be placed on dout.
   assign w_col_nxt  = (r_col == c_COL_LAST) ? 9'd0 : r_col + 9'd1;
   assign w_row_nxt  = (r_col != c_COL_LAST) ? r_row :
                       (r_row == c_ROW_LAST) ? 4'd0 : r_row + 4'd1;
   assign w_pos_zero = (w_row_nxt == 4'd0) && (w_col_nxt == 9'd0);

   // The last A2 of a frame enters on din exactly when the byte at position
   // FRM_LEN-1 moves onto dout (six bytes behind).
   assign w_at_fas   = (w_row_nxt == c_ROW_LAST) && (w_col_nxt == c_COL_LAST);

   // Window is the five previously stored bytes plus the byte on din now.
   assign w_win_ok   = (r_dly[4] == A1) && (r_dly[3] == A1) && (r_dly[2] == A1) &&
                       (r_dly[1] == A2) && (r_dly[0] == A2) && (din == A2);

   assign w_oof_nxt  = (w_state_nxt != ST_SYNC);
   assign w_lcnt_inc = (r_lcnt == 16'hFFFF) ? r_lcnt : r_lcnt + 16'd1;

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk19 or negedge rst19_n) begin
      if (!rst19_n) begin
         r_state <= ST_HUNT;
         r_good  <= 3'd0;
         r_bad   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_good  <= w_good_nxt;
         r_bad   <= w_bad_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_bad_nxt   = r_bad;
      w_fas_err   = 1'b0;
      w_load      = 1'b0;
      if (din_en) begin
         case (r_state)
            ST_HUNT: begin
               if (w_win_ok) begin
                  w_state_nxt = ST_PRESYNC;
                  w_good_nxt  = 3'd1;
                  w_load      = 1'b1;
               end
            end
            ST_PRESYNC: begin
               if (w_at_fas) begin
                  if (w_win_ok) begin
                     w_good_nxt = r_good + 3'd1;
                     if (w_good_nxt >= c_GOOD) begin
                        w_state_nxt = ST_SYNC;
                        w_bad_nxt   = 3'd0;
                     end
                  end else begin
                     w_fas_err   = 1'b1;
                     w_state_nxt = ST_HUNT;
                  end
               end
            end
            ST_SYNC: begin
               if (w_at_fas) begin
                  if (w_win_ok) begin
                     w_bad_nxt = 3'd0;
                  end else begin
                     w_fas_err = 1'b1;
                     w_bad_nxt = r_bad + 3'd1;
                     if (w_bad_nxt >= c_BAD) begin
                        w_state_nxt = ST_HUNT;
                     end
                  end
               end
            end
            default: w_state_nxt = ST_HUNT;
         endcase
      end
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk19 or negedge rst19_n) begin
      if (!rst19_n) begin
         for (int i = 0; i < 6; i++) r_dly[i] <= 8'd0;
         r_row   <= 4'd0;
         r_col   <= 9'd0;
         dout    <= 8'd0;
         dout_en <= 1'b0;
         sofo    <= 1'b0;
         rowo    <= 4'd0;
         colo    <= 9'd0;
         oof     <= 1'b1;
         fas_err <= 1'b0;
      end else begin
         dout_en <= din_en;
         sofo    <= 1'b0;
         fas_err <= w_fas_err;
         oof     <= w_oof_nxt;
         if (din_en) begin
            r_dly[0] <= din;
            for (int i = 1; i < 6; i++) r_dly[i] <= r_dly[i-1];
            dout <= r_dly[5];
            // Outputs use the state before this byte, so the byte that
            // completes the hunt still reports position 0 and no sofo.
            sofo <= (r_state != ST_HUNT) && w_pos_zero;
            rowo <= (r_state == ST_HUNT) ? 4'd0 : w_row_nxt;
            colo <= (r_state == ST_HUNT) ? 9'd0 : w_col_nxt;
            if (w_load) begin
               // Byte now going to dout is the one just before the first A1.
               r_row <= c_ROW_LAST;
               r_col <= c_COL_LAST;
            end else begin
               r_row <= w_row_nxt;
               r_col <= w_col_nxt;
            end
         end
      end
   end

   // ------------------------------------------------------------------ LOF
   always_ff @(posedge clk19 or negedge rst19_n) begin
      if (!rst19_n) begin
         r_lcnt <= 16'd0;
         lof    <= 1'b0;
      end else if (w_oof_nxt != oof) begin
         // An oof change always restarts integration, even on the byte that
         // would otherwise complete it.
         r_lcnt <= 16'd0;
      end else if (din_en) begin
         r_lcnt <= w_lcnt_inc;
         // lof follows oof once oof has been stable for the full period.
         if (w_lcnt_inc == c_LOF_CNT) begin
            lof <= oof;
         end
      end
   end

endmodule
`default_nettype wire
